// File: rtl/axil_reg_bank_pkg.sv
// Shared constants, FSM state types and sizing helpers for the AXI4-Lite register bank.
package axil_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Byte-address bits below the word index.
  function automatic int addr_lsb(input int data_w);
    return (data_w == 64) ? 3 : 2;
  endfunction

  function automatic int idx_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/axil_reg_bank_wr_ch.sv
// Write channel: independent AW/W capture, address decode, write FSM and B response.
// commit_o pulses for exactly one cycle when a write lands on a writable register.
module axil_reg_bank_wr_ch
  import axil_reg_bank_pkg::*;
#(
  parameter int C_DATA_W   = 32,
  parameter int C_ADDR_W   = 32,
  parameter int C_NUM_REGS = 16,
  parameter int C_NUM_RO   = 4,
  localparam int STRB_W    = C_DATA_W / 8,
  localparam int IDX_W     = idx_w(C_NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_ADDR_W-1:0] awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [C_DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0]   wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                commit_o,
  output logic [IDX_W-1:0]    commit_idx_o,
  output logic [C_DATA_W-1:0] commit_data_o,
  output logic [STRB_W-1:0]   commit_strb_o
);

  localparam int ADDR_LSB = addr_lsb(C_DATA_W);
  localparam int NUM_RW   = C_NUM_REGS - C_NUM_RO;
  localparam logic [C_ADDR_W-1:0] ADDR_LIMIT = C_ADDR_W'(C_NUM_REGS) << ADDR_LSB;

  wr_state_e             state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  aw_ok_q, aw_ok_d;
  logic [C_DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;

  logic                  aw_hs, w_hs, live_ok, cur_ok, commit;
  logic [IDX_W-1:0]      live_idx;

  // In WR_IDLE a dropped ready means that channel's beat is already held.
  always_comb begin
    aw_hs    = awvalid && awready_q;
    w_hs     = wvalid && wready_q;
    live_idx = awaddr[ADDR_LSB +: IDX_W];
    live_ok  = (awaddr < ADDR_LIMIT) && ({1'b0, live_idx} < (IDX_W+1)'(NUM_RW));
    cur_ok   = awready_q ? live_ok : aw_ok_q;
    commit   = (state_q == WR_IDLE) && (aw_hs || !awready_q) && (w_hs || !wready_q);

    commit_o      = commit && cur_ok;
    commit_idx_o  = awready_q ? live_idx : aw_idx_q;
    commit_data_o = wready_q ? wdata : w_data_q;
    commit_strb_o = wready_q ? wstrb : w_strb_q;

    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;

    case (state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_idx_d  = live_idx;
          aw_ok_d   = live_ok;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_data_d = wdata;
          w_strb_d = wstrb;
          wready_d = 1'b0;
        end
        if (commit) begin
          state_d   = WR_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = cur_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      WR_RESP: begin
        if (bready) begin
          state_d   = WR_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WR_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: RW control registers, RO status registers, per-register write pulses.
// Define AXIL_REG_BANK_WSTRB_EN to add the s_axi_wstrb port and byte-granular writes.
// Handshake rule on every channel: a beat transfers on a rising edge where valid && ready.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int                    C_DATA_W   = 32,
  parameter int                    C_ADDR_W   = 32,
  parameter int                    C_NUM_REGS = 16,
  parameter int                    C_NUM_RO   = 4,
  parameter logic [C_DATA_W-1:0]   C_RST_VAL  = '0,
  localparam int                   NUM_RW     = C_NUM_REGS - C_NUM_RO
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_areset,
  input  logic [C_ADDR_W-1:0]          s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [C_DATA_W-1:0]          s_axi_wdata,
`ifdef AXIL_REG_BANK_WSTRB_EN
  input  logic [C_DATA_W/8-1:0]        s_axi_wstrb,
`endif
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [C_ADDR_W-1:0]          s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [C_DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [NUM_RW*C_DATA_W-1:0]   ctrl_o,
  output logic [NUM_RW-1:0]            wr_pulse_o,
  input  logic [C_NUM_RO*C_DATA_W-1:0] status_i
);

  localparam int STRB_W   = C_DATA_W / 8;
  localparam int IDX_W    = idx_w(C_NUM_REGS);
  localparam int ADDR_LSB = addr_lsb(C_DATA_W);
  localparam logic [C_ADDR_W-1:0] ADDR_LIMIT = C_ADDR_W'(C_NUM_REGS) << ADDR_LSB;

  logic [STRB_W-1:0]   wstrb_int;
  logic                commit;
  logic [IDX_W-1:0]    commit_idx;
  logic [C_DATA_W-1:0] commit_data;
  logic [STRB_W-1:0]   commit_strb;

`ifdef AXIL_REG_BANK_WSTRB_EN
  assign wstrb_int = s_axi_wstrb;
`else
  assign wstrb_int = '1;
`endif

  axil_reg_bank_wr_ch #(
    .C_DATA_W   (C_DATA_W),
    .C_ADDR_W   (C_ADDR_W),
    .C_NUM_REGS (C_NUM_REGS),
    .C_NUM_RO   (C_NUM_RO)
  ) u_wr_ch (
    .clk           (s_axi_aclk),
    .rst           (s_axi_areset),
    .awaddr        (s_axi_awaddr),
    .awvalid       (s_axi_awvalid),
    .awready       (s_axi_awready),
    .wdata         (s_axi_wdata),
    .wstrb         (wstrb_int),
    .wvalid        (s_axi_wvalid),
    .wready        (s_axi_wready),
    .bresp         (s_axi_bresp),
    .bvalid        (s_axi_bvalid),
    .bready        (s_axi_bready),
    .commit_o      (commit),
    .commit_idx_o  (commit_idx),
    .commit_data_o (commit_data),
    .commit_strb_o (commit_strb)
  );

  logic [NUM_RW*C_DATA_W-1:0] ctrl_q, ctrl_d;
  logic [NUM_RW-1:0]          wr_pulse_q, wr_pulse_d;
  rd_state_e                  rd_state_q, rd_state_d;
  logic                       arready_q, arready_d;
  logic                       rvalid_q, rvalid_d;
  logic [C_DATA_W-1:0]        rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [IDX_W-1:0]           rd_idx;
  logic                       rd_oor;
  logic [C_DATA_W-1:0]        rd_val;

  always_comb begin
    ctrl_d     = ctrl_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (commit && ({1'b0, commit_idx} == (IDX_W+1)'(i))) begin
        wr_pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (commit_strb[b]) ctrl_d[i*C_DATA_W + b*8 +: 8] = commit_data[b*8 +: 8];
        end
      end
    end

    // Reads see ctrl_q, so a same-edge write is not yet visible.
    rd_idx = s_axi_araddr[ADDR_LSB +: IDX_W];
    rd_oor = s_axi_araddr >= ADDR_LIMIT;
    rd_val = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if ({1'b0, rd_idx} == (IDX_W+1)'(i)) rd_val = ctrl_q[i*C_DATA_W +: C_DATA_W];
    end
    for (int j = 0; j < C_NUM_RO; j++) begin
      if ({1'b0, rd_idx} == (IDX_W+1)'(NUM_RW + j)) rd_val = status_i[j*C_DATA_W +: C_DATA_W];
    end

    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid) begin
          rd_state_d = RD_DATA;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_oor ? '0 : rd_val;
          rresp_d    = rd_oor ? RESP_SLVERR : RESP_OKAY;
        end
      end
      RD_DATA: begin
        if (s_axi_rready) begin
          rd_state_d = RD_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ctrl_q     <= {NUM_RW{C_RST_VAL}};
      wr_pulse_q <= '0;
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ctrl_q     <= ctrl_d;
      wr_pulse_q <= wr_pulse_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign ctrl_o        = ctrl_q;
  assign wr_pulse_o    = wr_pulse_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule
